apb_timer_master: RTL and testbench



---
 rtl/apb_timer_pkg.sv | 18 +
 rtl/apb_timeout_ctr.sv | 33 +++
 rtl/apb_timer_master.sv | 149 ++++++++++++++
 tb/tb_apb_timer_master.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_timer_pkg.sv
// Shared definitions for the APB requester that drives the timer peripheral:
// FSM state encoding, default bus widths and the timer register map.
package apb_timer_pkg;

  localparam int unsigned APB_ADDR_W = 8;
  localparam int unsigned APB_DATA_W = 8;

  // Timer peripheral register map
  localparam logic [7:0] TCR_ADDR = 8'h00;
  localparam logic [7:0] TDR_ADDR = 8'h01;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_timeout_ctr.sv
// Wait-state watchdog for the ACCESS phase. Cleared while the bus is in
// SETUP, so it starts from zero on entry to ACCESS, and advances on each
// ACCESS cycle the slave holds PREADY low. "expired" flags the cycle in which
// the limit is reached; it requires PREADY low, so a slave that answers in
// that same cycle still completes normally.
module apb_timeout_ctr
  #(parameter int unsigned TIMEOUT_CYCLES = 16)
  (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic load,
    input  logic count_en,
    output logic expired
  );

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  // Wait-state counter: clear on load, step once per stalled ACCESS cycle
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + 1'b1;
    end
  end

  assign expired = count_en && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_timer_master.sv
// APB requester for the timer peripheral. Takes one read/write command at a
// time from a valid/ready channel, runs it through APB SETUP and ACCESS, and
// returns read data and error status on a valid/ready response channel.
// Optional feature: define APB_TIMEOUT_EN to abort ACCESS phases that stall
// for TIMEOUT_CYCLES cycles; without it ACCESS waits indefinitely for PREADY.
module apb_timer_master
  import apb_timer_pkg::*;
  #(
    parameter int unsigned ADDR_W         = APB_ADDR_W,
    parameter int unsigned DATA_W         = APB_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 16
  )
  (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
  );

  apb_state_e state;
  apb_state_e next_state;

  logic accept;
  logic access_done;
  logic timeout_hit;

  // A zero limit would abort before the slave could ever answer
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_timer_master: TIMEOUT_CYCLES must be at least 1");
  end

  assign accept      = cmd_valid && cmd_ready;
  assign access_done = (state == ACCESS) && (PREADY || timeout_hit);

`ifdef APB_TIMEOUT_EN
  apb_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .load     (state == SETUP),
    .count_en ((state == ACCESS) && !PREADY),
    .expired  (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // State register; reset drops straight back to IDLE, abandoning any transfer
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: SETUP always lasts one cycle, ACCESS lasts until the slave
  // answers or the watchdog gives up
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept) next_state = SETUP;
      SETUP:   next_state = ACCESS;
      ACCESS:  if (access_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Bus controls decode from state alone, so reset removes them immediately
  // and cmd_ready has no path from cmd_valid
  always_comb begin
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    busy      = 1'b0;
    cmd_ready = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = !rsp_valid;
      end
      SETUP: begin
        PSEL = 1'b1;
        busy = 1'b1;
      end
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        busy    = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Request fields are captured once per accepted command and then held,
  // which keeps them stable for the whole transfer and parked in IDLE
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PWRITE <= 1'b0;
      PADDR  <= '0;
      PWDATA <= '0;
    end else if (accept) begin
      PWRITE <= cmd_write;
      PADDR  <= cmd_addr;
      if (cmd_write) begin
        PWDATA <= cmd_wdata;
      end
    end
  end

  // Response capture at the end of ACCESS, held until the consumer takes it;
  // PRDATA and PSLVERR are only looked at when the slave signals completion
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (access_done) begin
      rsp_valid <= 1'b1;
      if (PREADY) begin
        rsp_rdata <= PWRITE ? '0 : PRDATA;
        rsp_err   <= PSLVERR;
      end else begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
      end
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apb_timer_master.sv
// Directed self-checking bench for apb_timer_master. The APB slave side is
// driven straight from the stimulus; the timeout scenarios are compiled in
// when APB_TIMEOUT_EN is defined, otherwise an unbounded-wait scenario runs.
module tb_apb_timer_master;

  logic       PCLK;
  logic       PRESETn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       busy;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSLVERR;

  int checkCount;
  int errCount;
  int penCount;

  apb_timer_master #(
    .ADDR_W        (8),
    .DATA_W        (8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .busy     (busy),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR)
  );

  // Free-running 100 MHz clock
  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, actual, expected);
    end
  endtask

  // Present a command and return one cycle after it is accepted (SETUP)
  task automatic applyStimulus(input logic write, input logic [7:0] addr, input logic [7:0] wdata);
    cmd_write = write;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_valid = 1'b1;
    for (int i = 0; i < 16 && !cmd_ready; i++) tick();
    checkOutput("cmd_accept_wait", 32'(cmd_ready), 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic consumeResponse();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("rsp_cleared", 32'(rsp_valid), 0);
  endtask

  initial begin
    checkCount = 0;
    errCount   = 0;
    PRESETn    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_write  = 1'b0;
    cmd_addr   = 8'h00;
    cmd_wdata  = 8'h00;
    rsp_ready  = 1'b0;
    PRDATA     = 8'h00;
    PREADY     = 1'b0;
    PSLVERR    = 1'b0;

    // ---- reset values ----
    #1;
    checkOutput("rst_psel",      32'(PSEL), 0);
    checkOutput("rst_penable",   32'(PENABLE), 0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 0);
    checkOutput("rst_busy",      32'(busy), 0);
    checkOutput("rst_paddr",     32'(PADDR), 0);
    checkOutput("rst_pwdata",    32'(PWDATA), 0);
    checkOutput("rst_pwrite",    32'(PWRITE), 0);
    tick();
    tick();
    PRESETn = 1'b1;
    tick();
    checkOutput("idle_cmd_ready", 32'(cmd_ready), 1);

    // ---- write, zero wait states ----
    PREADY = 1'b1;
    applyStimulus(1'b1, 8'h00, 8'hB0);
    checkOutput("wr_setup_psel",    32'(PSEL), 1);
    checkOutput("wr_setup_penable", 32'(PENABLE), 0);
    checkOutput("wr_setup_paddr",   32'(PADDR), 'h00);
    checkOutput("wr_setup_pwdata",  32'(PWDATA), 'hB0);
    checkOutput("wr_setup_pwrite",  32'(PWRITE), 1);
    checkOutput("wr_setup_busy",    32'(busy), 1);
    checkOutput("wr_setup_cmd_rdy", 32'(cmd_ready), 0);
    tick();
    checkOutput("wr_access_psel",    32'(PSEL), 1);
    checkOutput("wr_access_penable", 32'(PENABLE), 1);
    checkOutput("wr_access_pwdata",  32'(PWDATA), 'hB0);
    checkOutput("wr_access_rsp_vld", 32'(rsp_valid), 0);
    tick();
    checkOutput("wr_rsp_valid", 32'(rsp_valid), 1);
    checkOutput("wr_rsp_err",   32'(rsp_err), 0);
    checkOutput("wr_rsp_rdata", 32'(rsp_rdata), 'h00);
    checkOutput("wr_done_psel", 32'(PSEL), 0);
    checkOutput("wr_done_busy", 32'(busy), 0);
    checkOutput("wr_cmd_rdy_held", 32'(cmd_ready), 0);
    checkOutput("wr_paddr_hold", 32'(PADDR), 'h00);
    consumeResponse();
    checkOutput("wr_cmd_rdy_back", 32'(cmd_ready), 1);

    // ---- read with three wait states ----
    PREADY = 1'b0;
    applyStimulus(1'b0, 8'h01, 8'hEE);
    checkOutput("rd_setup_penable", 32'(PENABLE), 0);
    tick();
    penCount = 0;
    for (int k = 1; k <= 4; k++) begin
      if (PENABLE) penCount++;
      checkOutput("rd_paddr",     32'(PADDR), 'h01);
      checkOutput("rd_pwrite",    32'(PWRITE), 0);
      checkOutput("rd_pwdata_kept", 32'(PWDATA), 'hB0);
      checkOutput("rd_wait_rsp",  32'(rsp_valid), 0);
      if (k == 4) begin
        PREADY = 1'b1;
        PRDATA = 8'h5A;
      end
      tick();
    end
    checkOutput("rd_penable_cycles", penCount, 4);
    checkOutput("rd_rsp_valid", 32'(rsp_valid), 1);
    checkOutput("rd_rsp_rdata", 32'(rsp_rdata), 'h5A);
    checkOutput("rd_rsp_err",   32'(rsp_err), 0);
    checkOutput("rd_done_penable", 32'(PENABLE), 0);
    PRDATA = 8'h00;
    tick();
    checkOutput("rd_rdata_held", 32'(rsp_rdata), 'h5A);
    consumeResponse();

    // ---- PSLVERR outside ACCESS is ignored ----
    PSLVERR = 1'b1;
    applyStimulus(1'b1, 8'h01, 8'h3C);
    tick();
    PSLVERR = 1'b0;
    tick();
    checkOutput("err_ignored_valid", 32'(rsp_valid), 1);
    checkOutput("err_ignored_err",   32'(rsp_err), 0);
    consumeResponse();

    // ---- slave error on a read ----
    PSLVERR = 1'b1;
    PRDATA  = 8'h33;
    applyStimulus(1'b0, 8'h07, 8'h00);
    checkOutput("err_paddr", 32'(PADDR), 'h07);
    tick();
    tick();
    checkOutput("err_rsp_valid", 32'(rsp_valid), 1);
    checkOutput("err_rsp_err",   32'(rsp_err), 1);
    checkOutput("err_rsp_rdata", 32'(rsp_rdata), 'h33);
    checkOutput("err_pwdata_kept", 32'(PWDATA), 'h3C);
    PSLVERR = 1'b0;
    consumeResponse();

    // ---- response backpressure with a waiting command ----
    PRDATA = 8'h9E;
    applyStimulus(1'b0, 8'h01, 8'h00);
    tick();
    tick();
    PRDATA    = 8'h11;
    cmd_write = 1'b1;
    cmd_addr  = 8'h00;
    cmd_wdata = 8'h44;
    cmd_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp_cmd_ready", 32'(cmd_ready), 0);
      checkOutput("bp_psel",      32'(PSEL), 0);
      checkOutput("bp_rsp_valid", 32'(rsp_valid), 1);
      checkOutput("bp_rsp_rdata", 32'(rsp_rdata), 'h9E);
      checkOutput("bp_rsp_err",   32'(rsp_err), 0);
      tick();
    end
    rsp_ready = 1'b1;
    checkOutput("bp_consume_cmd_rdy", 32'(cmd_ready), 0);
    tick();
    rsp_ready = 1'b0;
    checkOutput("bp_after_rsp_valid", 32'(rsp_valid), 0);
    checkOutput("bp_after_cmd_rdy",   32'(cmd_ready), 1);
    checkOutput("bp_after_psel",      32'(PSEL), 0);
    tick();
    cmd_valid = 1'b0;
    checkOutput("bp_next_psel",    32'(PSEL), 1);
    checkOutput("bp_next_penable", 32'(PENABLE), 0);
    checkOutput("bp_next_pwdata",  32'(PWDATA), 'h44);
    tick();
    tick();
    checkOutput("bp_next_rsp_valid", 32'(rsp_valid), 1);
    checkOutput("bp_next_rsp_rdata", 32'(rsp_rdata), 'h00);
    consumeResponse();

    // ---- reset in the middle of ACCESS ----
    PREADY = 1'b0;
    applyStimulus(1'b0, 8'h01, 8'h00);
    tick();
    checkOutput("mid_psel",    32'(PSEL), 1);
    checkOutput("mid_penable", 32'(PENABLE), 1);
    #2;
    PRESETn = 1'b0;
    #1;
    checkOutput("mid_rst_psel",    32'(PSEL), 0);
    checkOutput("mid_rst_penable", 32'(PENABLE), 0);
    checkOutput("mid_rst_busy",    32'(busy), 0);
    checkOutput("mid_rst_paddr",   32'(PADDR), 0);
    checkOutput("mid_rst_rsp",     32'(rsp_valid), 0);
    PREADY = 1'b1;
    tick();
    PRESETn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("post_rst_no_rsp",  32'(rsp_valid), 0);
      checkOutput("post_rst_no_psel", 32'(PSEL), 0);
    end
    PRDATA = 8'h6C;
    applyStimulus(1'b0, 8'h01, 8'h00);
    tick();
    tick();
    checkOutput("post_rst_rsp_valid", 32'(rsp_valid), 1);
    checkOutput("post_rst_rsp_rdata", 32'(rsp_rdata), 'h6C);
    checkOutput("post_rst_rsp_err",   32'(rsp_err), 0);
    consumeResponse();

`ifdef APB_TIMEOUT_EN
    // ---- slave never answers: abort after 16 ACCESS cycles ----
    PREADY = 1'b0;
    PRDATA = 8'hFF;
    applyStimulus(1'b0, 8'h01, 8'h00);
    tick();
    penCount = 0;
    for (int k = 1; k <= 16; k++) begin
      if (PENABLE) penCount++;
      tick();
    end
    checkOutput("to_access_cycles", penCount, 16);
    checkOutput("to_psel",      32'(PSEL), 0);
    checkOutput("to_penable",   32'(PENABLE), 0);
    checkOutput("to_rsp_valid", 32'(rsp_valid), 1);
    checkOutput("to_rsp_err",   32'(rsp_err), 1);
    checkOutput("to_rsp_rdata", 32'(rsp_rdata), 'h00);
    checkOutput("to_busy",      32'(busy), 0);
    consumeResponse();

    // ---- slave answers on the 16th ACCESS cycle: completes normally ----
    PRDATA = 8'hA5;
    applyStimulus(1'b0, 8'h01, 8'h00);
    tick();
    for (int k = 1; k <= 16; k++) begin
      checkOutput("to_edge_penable", 32'(PENABLE), 1);
      if (k == 16) PREADY = 1'b1;
      tick();
    end
    checkOutput("to_edge_rsp_valid", 32'(rsp_valid), 1);
    checkOutput("to_edge_rsp_err",   32'(rsp_err), 0);
    checkOutput("to_edge_rsp_rdata", 32'(rsp_rdata), 'hA5);
    consumeResponse();
`else
    // ---- without the watchdog, ACCESS waits as long as the slave stalls ----
    PREADY = 1'b0;
    PRDATA = 8'hA5;
    applyStimulus(1'b0, 8'h01, 8'h00);
    tick();
    for (int k = 1; k <= 20; k++) begin
      checkOutput("wait_penable", 32'(PENABLE), 1);
      checkOutput("wait_no_rsp",  32'(rsp_valid), 0);
      tick();
    end
    PREADY = 1'b1;
    tick();
    checkOutput("wait_rsp_valid", 32'(rsp_valid), 1);
    checkOutput("wait_rsp_err",   32'(rsp_err), 0);
    checkOutput("wait_rsp_rdata", 32'(rsp_rdata), 'hA5);
    consumeResponse();
`endif

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
